// File: rtl/red_pitaya_pwm_gen.sv
// Multi-channel PWM generator with shadowed duty settings applied at frame boundaries.
// Define RED_PITAYA_PWM_DITHER_EN to build the per-period dither (BW periods per frame).
module red_pitaya_pwm_gen #(
  parameter int unsigned CHN  = 4,
  parameter int unsigned CW   = 8,
  parameter int unsigned BW   = 16,
  parameter int unsigned FULL = 156
) (
  input  logic                      adc_clk_i,
  input  logic                      adc_rstn_i,
  input  logic [CHN*(CW+BW)-1:0]    cfg_dat_i,
  input  logic                      cfg_we_i,
  input  logic [CHN-1:0]            pwm_inv_i,
  output logic [CHN-1:0]            pwm_o,
  output logic                      pwm_sync_o,
  output logic                      upd_pend_o
);

  localparam int unsigned   DW    = CW + BW;
  localparam logic [CW-1:0] FullC = CW'(FULL);
  localparam logic [CW-1:0] SyncC = CW'(FULL - 1);
  localparam logic [CW:0]   FullE = (CW+1)'(FULL);

  logic [CW-1:0]  vcnt_q, vcnt_d;
  logic           period_end;
  logic           frame_end;
  logic [CHN-1:0] dit_bit;

  assign period_end = (vcnt_q == FullC);

  always_comb begin
    vcnt_d = period_end ? CW'(1) : vcnt_q + CW'(1);
  end

  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) vcnt_q <= '0;
    else             vcnt_q <= vcnt_d;
  end

`ifdef RED_PITAYA_PWM_DITHER_EN
  localparam int unsigned    BcW   = (BW > 1) ? $clog2(BW) : 1;
  localparam logic [BcW-1:0] BLast = BcW'(BW - 1);

  logic [BcW-1:0] bcnt_q, bcnt_d;
  logic [BW-1:0]  shd_dit_q [CHN];
  logic [BW-1:0]  act_dit_q [CHN];

  assign frame_end  = period_end && (bcnt_q == BLast);
  assign pwm_sync_o = (vcnt_q == SyncC) && (bcnt_q == BLast);

  always_comb begin
    bcnt_d = bcnt_q;
    if (period_end) bcnt_d = (bcnt_q == BLast) ? '0 : bcnt_q + BcW'(1);
  end

  // Active dither shifts once per period so bit 0 always belongs to the current period.
  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      bcnt_q <= '0;
      for (int c = 0; c < CHN; c++) begin
        shd_dit_q[c] <= '0;
        act_dit_q[c] <= '0;
      end
    end else begin
      bcnt_q <= bcnt_d;
      for (int c = 0; c < CHN; c++) begin
        if (cfg_we_i)        shd_dit_q[c] <= cfg_dat_i[c*DW +: BW];
        if (frame_end)       act_dit_q[c] <= shd_dit_q[c];
        else if (period_end) act_dit_q[c] <= act_dit_q[c] >> 1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHN; c++) dit_bit[c] = act_dit_q[c][0];
  end
`else
  logic unused_dither;

  assign frame_end  = period_end;
  assign pwm_sync_o = (vcnt_q == SyncC);
  assign dit_bit    = '0;

  always_comb begin
    unused_dither = 1'b0;
    for (int c = 0; c < CHN; c++) unused_dither = unused_dither ^ (^cfg_dat_i[c*DW +: BW]);
  end
`endif

  logic [CW-1:0] shd_val_q [CHN];
  logic [CW-1:0] act_val_q [CHN];
  logic          upd_pend_q, upd_pend_d;

  // A write on the boundary cycle wins over the clear; the transfer sees the old shadow.
  always_comb begin
    upd_pend_d = upd_pend_q;
    if (cfg_we_i)       upd_pend_d = 1'b1;
    else if (frame_end) upd_pend_d = 1'b0;
  end

  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      upd_pend_q <= 1'b0;
      for (int c = 0; c < CHN; c++) begin
        shd_val_q[c] <= '0;
        act_val_q[c] <= '0;
      end
    end else begin
      upd_pend_q <= upd_pend_d;
      for (int c = 0; c < CHN; c++) begin
        if (cfg_we_i)  shd_val_q[c] <= cfg_dat_i[c*DW+BW +: CW];
        if (frame_end) act_val_q[c] <= shd_val_q[c];
      end
    end
  end

  assign upd_pend_o = upd_pend_q;

  logic [CW:0]    eff_d [CHN];
  logic [CW:0]    eff_q [CHN];
  logic [CW-1:0]  vcnt_p_q;
  logic [CHN-1:0] cmp_d, cmp_q, pwm_q;

  always_comb begin
    for (int c = 0; c < CHN; c++) begin
      logic [CW:0] sum;
      sum      = {1'b0, act_val_q[c]} + {{CW{1'b0}}, dit_bit[c]};
      eff_d[c] = (sum > FullE) ? FullE : sum;
    end
  end

  // vcnt 0 only exists straight after reset; keep the raw output low there.
  always_comb begin
    for (int c = 0; c < CHN; c++) begin
      cmp_d[c] = ((vcnt_p_q != '0) && ({1'b0, vcnt_p_q} <= eff_q[c])) ^ pwm_inv_i[c];
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      vcnt_p_q <= '0;
      cmp_q    <= '0;
      pwm_q    <= '0;
      for (int c = 0; c < CHN; c++) eff_q[c] <= '0;
    end else begin
      vcnt_p_q <= vcnt_q;
      cmp_q    <= cmp_d;
      pwm_q    <= cmp_q;
      for (int c = 0; c < CHN; c++) eff_q[c] <= eff_d[c];
    end
  end

  assign pwm_o = pwm_q;

endmodule
